corr_readout_sched: RTL

CORR_READOUT_SCHED -- requirements
Module: corr_readout_sched

---
 rtl/corr_readout_sched.sv | 110 +++++++++++
 1 files changed

// File: rtl/corr_readout_sched.sv
// corr_readout_sched: round-robin correlator readout over a shared register bus
// into a first-word-fall-through result FIFO, yielding the bus to the host when idle.
module corr_readout_sched #(
  parameter int          NUM_CORR   = 16,
  parameter logic [31:0] CNT_BASE   = 32'hFE000690,
  parameter logic [31:0] CH_STRIDE  = 32'h00000010,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                Enable,
  input  logic [NUM_CORR-1:0] CorrSeen,
  input  logic                HostReq,
  output logic                BusGnt,
  output logic [31:0]         addr,
  output logic                read,
  input  logic [31:0]         Rdata,
  output logic                ResultValid,
  input  logic                ResultPop,
  output logic [3:0]          ResultId,
  output logic [31:0]         ResultCnt,
  output logic [63:0]         ResultCorr,
  output logic                ResultStale,
  output logic                Busy,
  output logic                Overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  typedef enum logic [2:0] {IDLE, RD_CNT, RD_LOW, RD_HIGH, RD_STAT, PUSH} state_t;
  state_t state;
  logic [3:0] last, pick;
  logic any, empty, full, pop, stale;
  logic [31:0] cnt, low, high;
  logic [PW-1:0] wptr, rptr;
  logic [100:0] mem [FIFO_DEPTH];
  logic [100:0] head;
  assign empty = wptr == rptr;
  assign full = (wptr - rptr) == PW'(FIFO_DEPTH);
  assign pop = ResultPop & ~empty;
  assign Busy = state != IDLE;
  assign BusGnt = rst & HostReq & (state == IDLE);
  assign ResultValid = ~empty;
  assign head = ResultValid ? mem[rptr[AW-1:0]] : '0;
  assign {ResultId, ResultCnt, ResultCorr, ResultStale} = head;
  // Scan downward so the nearest channel after the last grant wins.
  always_comb begin
    pick = last;
    any = 1'b0;
    for (int i = NUM_CORR; i >= 1; i--)
      if (CorrSeen[(int'(last) + i) % NUM_CORR]) begin
        pick = 4'((int'(last) + i) % NUM_CORR);
        any = 1'b1;
      end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      last <= 4'(NUM_CORR - 1);
      addr <= '0;
      read <= 1'b0;
      Overflow <= 1'b0;
      cnt <= '0;
      low <= '0;
      high <= '0;
      stale <= 1'b0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      rptr <= rptr + PW'(pop);
      case (state)
        IDLE: if (!HostReq && Enable && any) begin
          if (full) Overflow <= 1'b1;
          else begin
            state <= RD_CNT;
            last <= pick;
            addr <= CNT_BASE + 32'(pick) * CH_STRIDE;
            read <= 1'b1;
          end
        end
        RD_CNT: begin
          cnt <= Rdata;
          addr <= addr + 32'd4;
          state <= RD_LOW;
        end
        RD_LOW: begin
          low <= Rdata;
          addr <= addr + 32'd4;
          state <= RD_HIGH;
        end
        RD_HIGH: begin
          high <= Rdata;
          addr <= addr + 32'd4;
          state <= RD_STAT;
        end
        RD_STAT: begin
          stale <= ~Rdata[0];
          addr <= '0;
          read <= 1'b0;
          state <= PUSH;
        end
        PUSH: begin
          wptr <= wptr + PW'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge clk)
    if (state == PUSH) mem[wptr[AW-1:0]] <= {last, cnt, high, low, stale};
endmodule
